// File: rtl/lif_pkg.sv
// Shared types, default geometry and saturation helper for the LIF neuron layer.
package lif_pkg;

    localparam int unsigned N_NEURONS_DEF = 4;
    localparam int unsigned N_INPUTS_DEF  = 8;
    localparam int unsigned W_U_DEF       = 8;
    localparam int unsigned W_R_DEF       = 3;
    localparam int unsigned W_SHIFT       = 3;
    localparam int unsigned W_IDX_DEF     = $clog2(N_NEURONS_DEF);
    localparam int unsigned W_SUM_DEF     = $clog2(N_INPUTS_DEF + 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Clamp a signed value to the range of a w-bit two's complement number.
    function automatic logic signed [31:0] sat_s(input logic signed [31:0] v,
                                                 input int unsigned w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -hi - 32'sd1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/lif_neuron_layer_if.sv
// Config, weight-write, input and start/busy/done bus of the LIF neuron layer.
interface lif_neuron_layer_if
    import lif_pkg::*;
#(
    parameter int unsigned N_NEURONS = N_NEURONS_DEF,
    parameter int unsigned N_INPUTS  = N_INPUTS_DEF,
    parameter int unsigned W_U       = W_U_DEF,
    parameter int unsigned W_R       = W_R_DEF
);
    localparam int unsigned W_IDX = $clog2(N_NEURONS);

    logic [W_SHIFT-1:0]   cfg_shift;
    logic [W_U-1:0]       cfg_theta;
    logic [W_R-1:0]       cfg_refractory;
    logic                 w_we;
    logic [W_IDX-1:0]     w_addr;
    logic [N_INPUTS-1:0]  w_data;
    logic [N_INPUTS-1:0]  x_in;
    logic                 start;
    logic                 busy;
    logic                 done;
    logic [N_NEURONS-1:0] spikes;

    modport master (
        output cfg_shift, cfg_theta, cfg_refractory, w_we, w_addr, w_data, x_in, start,
        input  busy, done, spikes
    );

    modport slave (
        input  cfg_shift, cfg_theta, cfg_refractory, w_we, w_addr, w_data, x_in, start,
        output busy, done, spikes
    );

endinterface

// File: rtl/lif_update.sv
// Combinational single-neuron update: leak, synaptic sum, reset-by-subtraction,
// saturation, threshold compare and refractory next-state.
module lif_update
    import lif_pkg::*;
#(
    parameter int unsigned N_INPUTS = N_INPUTS_DEF,
    parameter int unsigned W_U      = W_U_DEF,
    parameter int unsigned W_R      = W_R_DEF
) (
    input  logic signed [W_U-1:0] u_i,
    input  logic                  was_spike_i,
    input  logic [W_R-1:0]        refr_i,
    input  logic [N_INPUTS-1:0]   w_i,
    input  logic [N_INPUTS-1:0]   x_i,
    input  logic [W_SHIFT-1:0]    shift_i,
    input  logic [W_U-1:0]        theta_i,
    input  logic [W_R-1:0]        refr_cfg_i,
    output logic signed [W_U-1:0] u_new_c,
    output logic                  spike_c,
    output logic [W_R-1:0]        refr_new_c
);
    localparam int unsigned W_S = $clog2(N_INPUTS + 1);
    localparam int unsigned W_X = W_U + 2;

    logic [N_INPUTS-1:0]   hits;
    logic [W_S-1:0]        sum;
    logic signed [W_X-1:0] u_x;
    logic signed [W_X-1:0] beta;
    logic signed [W_X-1:0] sum_x;
    logic signed [W_X-1:0] sub_x;
    logic signed [W_X-1:0] acc;
    logic signed [W_X-1:0] u_new_x;
    logic signed [W_X-1:0] theta_x;
    logic                  refractory;

    always_comb begin
        hits = w_i & x_i;
        sum  = '0;
        for (int j = 0; j < int'(N_INPUTS); j++) begin
            sum = sum + W_S'(hits[j]);
        end

        refractory = (refr_i != '0);
        u_x        = W_X'(u_i);
        beta       = (shift_i == '0) ? u_x : (u_x - (u_x >>> shift_i));
        sum_x      = refractory ? '0 : W_X'(sum);
        theta_x    = W_X'(theta_i);
        sub_x      = was_spike_i ? theta_x : '0;
        acc        = beta + sum_x - sub_x;

        u_new_c    = W_U'(sat_s(32'(acc), W_U));
        u_new_x    = W_X'(u_new_c);
        spike_c    = !refractory && (u_new_x >= theta_x);

        // A neuron in refractory counts down; otherwise a fresh spike arms the counter.
        if (refractory) begin
            refr_new_c = refr_i - W_R'(1);
        end else if (spike_c) begin
            refr_new_c = refr_cfg_i;
        end else begin
            refr_new_c = '0;
        end
    end

endmodule

// File: rtl/lif_neuron_layer.sv
// Time-multiplexed LIF neuron layer: one start sweeps every neuron through a shared
// update datapath, one neuron per cycle, then publishes the spike vector.
module lif_neuron_layer
    import lif_pkg::*;
#(
    parameter int unsigned N_NEURONS = N_NEURONS_DEF,
    parameter int unsigned N_INPUTS  = N_INPUTS_DEF,
    parameter int unsigned W_U       = W_U_DEF,
    parameter int unsigned W_R       = W_R_DEF
) (
    input logic               clk,
    input logic               rst_n,
    lif_neuron_layer_if.slave bus
);
    localparam int unsigned W_IDX = $clog2(N_NEURONS);

    state_e                state_q, state_d;
    logic [W_IDX-1:0]      idx_q, idx_d;
    logic [N_INPUTS-1:0]   x_q, x_d;
    logic [W_SHIFT-1:0]    shift_q, shift_d;
    logic [W_U-1:0]        theta_q, theta_d;
    logic [W_R-1:0]        refr_cfg_q, refr_cfg_d;
    logic signed [W_U-1:0] u_q [N_NEURONS];
    logic signed [W_U-1:0] u_d [N_NEURONS];
    logic [W_R-1:0]        refr_q [N_NEURONS];
    logic [W_R-1:0]        refr_d [N_NEURONS];
    logic [N_INPUTS-1:0]   w_q [N_NEURONS];
    logic [N_INPUTS-1:0]   w_d [N_NEURONS];
    logic [N_NEURONS-1:0]  was_spike_q, was_spike_d;
    logic [N_NEURONS-1:0]  work_q, work_d;
    logic [N_NEURONS-1:0]  spikes_q, spikes_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic signed [W_U-1:0] u_new_c;
    logic                  spike_c;
    logic [W_R-1:0]        refr_new_c;

    lif_update #(
        .N_INPUTS (N_INPUTS),
        .W_U      (W_U),
        .W_R      (W_R)
    ) u_update (
        .u_i         (u_q[idx_q]),
        .was_spike_i (was_spike_q[idx_q]),
        .refr_i      (refr_q[idx_q]),
        .w_i         (w_q[idx_q]),
        .x_i         (x_q),
        .shift_i     (shift_q),
        .theta_i     (theta_q),
        .refr_cfg_i  (refr_cfg_q),
        .u_new_c     (u_new_c),
        .spike_c     (spike_c),
        .refr_new_c  (refr_new_c)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        x_d         = x_q;
        shift_d     = shift_q;
        theta_d     = theta_q;
        refr_cfg_d  = refr_cfg_q;
        u_d         = u_q;
        refr_d      = refr_q;
        w_d         = w_q;
        was_spike_d = was_spike_q;
        work_d      = work_q;
        spikes_d    = spikes_q;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.w_we) begin
                    w_d[bus.w_addr] = bus.w_data;
                end
                if (bus.start) begin
                    x_d        = bus.x_in;
                    shift_d    = bus.cfg_shift;
                    theta_d    = bus.cfg_theta;
                    refr_cfg_d = bus.cfg_refractory;
                    idx_d      = '0;
                    work_d     = '0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                u_d[idx_q]         = u_new_c;
                refr_d[idx_q]      = refr_new_c;
                was_spike_d[idx_q] = spike_c;
                work_d[idx_q]      = spike_c;
                idx_d              = idx_q + W_IDX'(1);
                // Last neuron: publish the whole vector at once and return to IDLE.
                if (idx_q == W_IDX'(N_NEURONS - 1)) begin
                    idx_d    = '0;
                    spikes_d = work_d;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            x_q         <= '0;
            shift_q     <= '0;
            theta_q     <= '0;
            refr_cfg_q  <= '0;
            was_spike_q <= '0;
            work_q      <= '0;
            spikes_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            for (int i = 0; i < int'(N_NEURONS); i++) begin
                u_q[i]    <= '0;
                refr_q[i] <= '0;
                w_q[i]    <= '0;
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            x_q         <= x_d;
            shift_q     <= shift_d;
            theta_q     <= theta_d;
            refr_cfg_q  <= refr_cfg_d;
            was_spike_q <= was_spike_d;
            work_q      <= work_d;
            spikes_q    <= spikes_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            u_q         <= u_d;
            refr_q      <= refr_d;
            w_q         <= w_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.spikes = spikes_q;

endmodule

// File: tb/tb_lif_neuron_layer.sv
// Directed self-checking bench for lif_neuron_layer (4 neurons, 8 synapses, W_U=8, W_R=3).
module tb_lif_neuron_layer;
    import lif_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    lif_neuron_layer_if #(.N_NEURONS(4), .N_INPUTS(8), .W_U(8), .W_R(3)) ifc ();

    lif_neuron_layer #(.N_NEURONS(4), .N_INPUTS(8), .W_U(8), .W_R(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    task automatic apply_reset();
        ifc.cfg_shift      = 3'd0;
        ifc.cfg_theta      = 8'd10;
        ifc.cfg_refractory = 3'd0;
        ifc.w_we           = 1'b0;
        ifc.w_addr         = 2'd0;
        ifc.w_data         = 8'h00;
        ifc.x_in           = 8'h00;
        ifc.start          = 1'b0;
        rst_n              = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic write_w(input logic [1:0] addr, input logic [7:0] data);
        @(negedge clk);
        ifc.w_we   = 1'b1;
        ifc.w_addr = addr;
        ifc.w_data = data;
        @(negedge clk);
        ifc.w_we   = 1'b0;
    endtask

    // Runs one timestep; returns cycles from the accepting edge to done (4 expected).
    task automatic do_step(input logic [7:0] x, output int lat);
        @(negedge clk);
        ifc.x_in  = x;
        ifc.start = 1'b1;
        @(negedge clk);
        ifc.start = 1'b0;
        lat = 0;
        while (ifc.done !== 1'b1 && lat < 16) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 16) begin
            n_fail++;
            $display("FAIL step_timeout: done not seen within %0d cycles", lat);
        end
    endtask

    task automatic test_reset();
        int lat;
        apply_reset();
        n_tests++;
        if (ifc.busy !== 1'b0 || ifc.done !== 1'b0 || ifc.spikes !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_outputs: busy=%b done=%b spikes=%b, want 0 0 0000",
                     ifc.busy, ifc.done, ifc.spikes);
        end
        n_tests++;
        if (dut.u_q[0] !== 8'sd0 || dut.w_q[3] !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_state: u0=%0d w3=%h, want 0 00", dut.u_q[0], dut.w_q[3]);
        end
        do_step(8'h00, lat);
        n_tests++;
        if (ifc.spikes !== 4'b0000 || lat != 4) begin
            n_fail++;
            $display("FAIL reset_zero_step: spikes=%b lat=%0d, want 0000 4", ifc.spikes, lat);
        end
    endtask

    task automatic test_integrate();
        logic signed [7:0] exp_u [4];
        logic [3:0]        exp_s [4];
        int                lat;
        exp_u = '{8'sd4, 8'sd8, 8'sd12, 8'sd6};
        exp_s = '{4'b0000, 4'b0000, 4'b0001, 4'b0000};
        apply_reset();
        write_w(2'd0, 8'hFF);
        ifc.cfg_theta = 8'd10;
        for (int i = 0; i < 4; i++) begin
            do_step(8'h0F, lat);
            n_tests++;
            if (dut.u_q[0] !== exp_u[i] || ifc.spikes !== exp_s[i]) begin
                n_fail++;
                $display("FAIL integrate_step%0d: u0=%0d spikes=%b, want %0d %b",
                         i, dut.u_q[0], ifc.spikes, exp_u[i], exp_s[i]);
            end
            if (i == 0) begin
                n_tests++;
                if (lat != 4) begin
                    n_fail++;
                    $display("FAIL integrate_latency: got %0d cycles, want 4", lat);
                end
            end
        end
    endtask

    task automatic test_leak();
        logic signed [7:0] exp_u [3];
        int                lat;
        exp_u = '{8'sd32, 8'sd16, 8'sd8};
        apply_reset();
        write_w(2'd0, 8'hFF);
        ifc.cfg_theta = 8'd100;
        for (int i = 0; i < 8; i++) do_step(8'hFF, lat);
        n_tests++;
        if (dut.u_q[0] !== 8'sd64 || ifc.spikes !== 4'b0000) begin
            n_fail++;
            $display("FAIL leak_charge: u0=%0d spikes=%b, want 64 0000", dut.u_q[0], ifc.spikes);
        end
        ifc.cfg_shift = 3'd1;
        for (int i = 0; i < 3; i++) begin
            do_step(8'h00, lat);
            n_tests++;
            if (dut.u_q[0] !== exp_u[i] || ifc.spikes !== 4'b0000) begin
                n_fail++;
                $display("FAIL leak_step%0d: u0=%0d spikes=%b, want %0d 0000",
                         i, dut.u_q[0], ifc.spikes, exp_u[i]);
            end
        end
    endtask

    task automatic test_saturation();
        int lat;
        apply_reset();
        write_w(2'd0, 8'hFF);
        ifc.cfg_theta = 8'd127;
        for (int i = 0; i < 15; i++) do_step(8'hFF, lat);
        n_tests++;
        if (dut.u_q[0] !== 8'sd120 || ifc.spikes !== 4'b0000) begin
            n_fail++;
            $display("FAIL sat_step15: u0=%0d spikes=%b, want 120 0000", dut.u_q[0], ifc.spikes);
        end
        do_step(8'hFF, lat);
        n_tests++;
        if (dut.u_q[0] !== 8'sd127 || ifc.spikes !== 4'b0001) begin
            n_fail++;
            $display("FAIL sat_clamp: u0=%0d spikes=%b, want 127 0001", dut.u_q[0], ifc.spikes);
        end
        do_step(8'hFF, lat);
        n_tests++;
        if (dut.u_q[0] !== 8'sd8 || ifc.spikes !== 4'b0000) begin
            n_fail++;
            $display("FAIL sat_after: u0=%0d spikes=%b, want 8 0000", dut.u_q[0], ifc.spikes);
        end
    endtask

    task automatic test_refractory();
        logic signed [7:0] exp_u [7];
        logic [3:0]        exp_s [7];
        int                lat;
        exp_u = '{8'sd4, 8'sd8, 8'sd12, 8'sd2, 8'sd2, 8'sd6, 8'sd10};
        exp_s = '{4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001};
        apply_reset();
        write_w(2'd0, 8'hFF);
        ifc.cfg_theta      = 8'd10;
        ifc.cfg_refractory = 3'd2;
        for (int i = 0; i < 7; i++) begin
            do_step(8'h0F, lat);
            n_tests++;
            if (dut.u_q[0] !== exp_u[i] || ifc.spikes !== exp_s[i]) begin
                n_fail++;
                $display("FAIL refr_step%0d: u0=%0d spikes=%b, want %0d %b",
                         i, dut.u_q[0], ifc.spikes, exp_u[i], exp_s[i]);
            end
        end
    endtask

    task automatic test_handshake();
        int lat;
        int extra_done;
        apply_reset();
        write_w(2'd1, 8'h55);
        write_w(2'd2, 8'hFF);
        ifc.cfg_theta = 8'd3;
        @(negedge clk);
        ifc.x_in  = 8'h0F;
        ifc.start = 1'b1;
        @(negedge clk);
        ifc.start = 1'b0;
        @(negedge clk);
        ifc.start  = 1'b1;
        ifc.w_we   = 1'b1;
        ifc.w_addr = 2'd1;
        ifc.w_data = 8'hAA;
        @(negedge clk);
        ifc.start = 1'b0;
        ifc.w_we  = 1'b0;
        lat = 2;
        while (ifc.done !== 1'b1 && lat < 16) begin
            @(negedge clk);
            lat++;
        end
        n_tests++;
        if (lat != 4 || ifc.spikes !== 4'b0100) begin
            n_fail++;
            $display("FAIL hs_sweep: lat=%0d spikes=%b, want 4 0100", lat, ifc.spikes);
        end
        extra_done = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ifc.done === 1'b1 || ifc.busy === 1'b1) extra_done++;
        end
        n_tests++;
        if (extra_done != 0) begin
            n_fail++;
            $display("FAIL hs_start_ignored: %0d busy/done cycles after sweep, want 0", extra_done);
        end
        n_tests++;
        if (dut.w_q[1] !== 8'h55) begin
            n_fail++;
            $display("FAIL hs_we_dropped: w1=%h, want 55", dut.w_q[1]);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        apply_reset();
        write_w(2'd0, 8'hFF);
        ifc.cfg_theta = 8'd10;
        do_step(8'h0F, lat);
        ifc.start = 1'b1;
        @(negedge clk);
        ifc.start     = 1'b0;
        ifc.cfg_theta = 8'd1;
        ifc.x_in      = 8'h00;
        n_tests++;
        if (ifc.busy !== 1'b1 || ifc.done !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_accept: busy=%b done=%b, want 1 0", ifc.busy, ifc.done);
        end
        lat = 0;
        while (ifc.done !== 1'b1 && lat < 16) begin
            @(negedge clk);
            lat++;
        end
        n_tests++;
        if (lat != 4 || dut.u_q[0] !== 8'sd8 || ifc.spikes !== 4'b0000) begin
            n_fail++;
            $display("FAIL b2b_latched: lat=%0d u0=%0d spikes=%b, want 4 8 0000",
                     lat, dut.u_q[0], ifc.spikes);
        end
        ifc.cfg_theta = 8'd10;
    endtask

    task automatic test_abort();
        int seen_done;
        apply_reset();
        write_w(2'd0, 8'hFF);
        ifc.cfg_theta = 8'd100;
        @(negedge clk);
        ifc.x_in  = 8'hFF;
        ifc.start = 1'b1;
        @(negedge clk);
        ifc.start = 1'b0;
        @(negedge clk);
        n_tests++;
        if (dut.u_q[0] !== 8'sd8 || ifc.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_mid: u0=%0d busy=%b, want 8 1", dut.u_q[0], ifc.busy);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (ifc.busy !== 1'b0 || dut.u_q[0] !== 8'sd0 || dut.w_q[0] !== 8'h00) begin
            n_fail++;
            $display("FAIL abort_clear: busy=%b u0=%0d w0=%h, want 0 0 00",
                     ifc.busy, dut.u_q[0], dut.w_q[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ifc.done === 1'b1) seen_done++;
        end
        n_tests++;
        if (seen_done != 0 || ifc.spikes !== 4'b0000) begin
            n_fail++;
            $display("FAIL abort_no_done: done cycles=%0d spikes=%b, want 0 0000",
                     seen_done, ifc.spikes);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        test_reset();
        test_integrate();
        test_leak();
        test_saturation();
        test_refractory();
        test_handshake();
        test_back_to_back();
        test_abort();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
